nios_lcd_hd44780_ctrl: RTL

//  Downstream of the 32-bit LCD output PIO. Consumes the PIO out_port word as a command

---
 rtl/nios_lcd_hd44780_ctrl.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/nios_lcd_hd44780_ctrl.sv
// -----------------------------------------------------------------------------
// nios_lcd_hd44780_ctrl
//
// Purpose:
//   Sits behind a 32-bit Nios output PIO and treats its out_port word as a
//   command mailbox for an HD44780 character LCD (8-bit bus, write-only).
//   Each accepted command is presented on the LCD bus with setup, enable and
//   hold timing, then the controller waits out the LCD execution time.
//   Software polls status_word through an input PIO instead of spinning in
//   delay loops.
//
// Handshake:
//   Software writes byte/RS and flips bit 31 (GO). A command is launched when
//   GO differs from the ack bit, which then takes the GO value. Because the
//   comparison is against ack rather than against the previous GO sample,
//   a flip made while busy is held pending and launches on the first idle
//   cycle. Two flips while busy return GO to ack, so nothing is launched.
//
// Ports:
//   clk          in   1   system clock
//   reset_n      in   1   synchronous active-low reset
//   cmd_word     in   32  [7:0] byte, [8] RS (0=instr, 1=data), [31] GO toggle
//   lcd_data     out  8   LCD DB7..DB0
//   lcd_rs       out  1   LCD register select
//   lcd_rw       out  1   LCD R/W, always 0
//   lcd_en       out  1   LCD enable strobe (registered)
//   busy         out  1   high while a transaction is in progress (registered)
//   status_word  out  32  {ack, 30'b0, busy}
//
// States:
//   state     | meaning
//   ----------+----------------------------------------------------------
//   ST_IDLE   | waiting for GO != ack; bus holds last byte/RS
//   ST_SETUP  | byte/RS stable, EN low, T_SETUP cycles
//   ST_ENABLE | EN high, T_EN cycles
//   ST_HOLD   | EN low, byte/RS still held, T_HOLD cycles
//   ST_WAIT   | LCD executing, T_SHORT or T_LONG cycles
//
// Timing: the phase counter is a down-counter loaded with (T - 1) on entry
// to a state; the state exits on the edge where the count is zero, so each
// state occupies exactly T cycles and the counter never wraps.
// -----------------------------------------------------------------------------
module nios_lcd_hd44780_ctrl #(
    parameter int T_SETUP = 4,
    parameter int T_EN    = 12,
    parameter int T_HOLD  = 4,
    parameter int T_SHORT = 2000,
    parameter int T_LONG  = 82000,
    parameter int CNT_W   = 17
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] cmd_word,
    output logic [7:0]  lcd_data,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_en,
    output logic        busy,
    output logic [31:0] status_word
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ENABLE,
        ST_HOLD,
        ST_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(T_EN - 1);
    localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] LD_SHORT = CNT_W'(T_SHORT - 1);
    localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(T_LONG - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       data_q, data_d;
    logic             rs_q, rs_d;
    logic             ack_q, ack_d;
    logic             long_q, long_d;
    logic             en_q, en_d;
    logic             busy_q, busy_d;

    logic             go;
    logic             cmd_rs;
    logic [7:0]       cmd_byte;
    logic             cmd_is_long;
    logic             cnt_zero;
    logic             unused_cmd_bits;

    assign go       = cmd_word[31];
    assign cmd_rs   = cmd_word[8];
    assign cmd_byte = cmd_word[7:0];

    // Bits [30:9] of the mailbox carry no meaning for this block.
    assign unused_cmd_bits = ^cmd_word[30:9];

    // Clear display (0x01) and return home (0x02/0x03) need the long
    // execution wait; everything else, including all data writes, is short.
    assign cmd_is_long = !cmd_rs && (cmd_byte[7:2] == 6'd0) && (cmd_byte[1:0] != 2'd0);

    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        rs_d    = rs_q;
        ack_d   = ack_q;
        long_d  = long_q;
        en_d    = 1'b0;
        busy_d  = busy_q;

        unique case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (go != ack_q) begin
                    state_d = ST_SETUP;
                    cnt_d   = LD_SETUP;
                    busy_d  = 1'b1;
                    ack_d   = go;
                    data_d  = cmd_byte;
                    rs_d    = cmd_rs;
                    long_d  = cmd_is_long;
                end
            end

            ST_SETUP: begin
                busy_d = 1'b1;
                if (cnt_zero) begin
                    state_d = ST_ENABLE;
                    cnt_d   = LD_EN;
                    en_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_ENABLE: begin
                busy_d = 1'b1;
                en_d   = 1'b1;
                if (cnt_zero) begin
                    state_d = ST_HOLD;
                    cnt_d   = LD_HOLD;
                    en_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_HOLD: begin
                busy_d = 1'b1;
                if (cnt_zero) begin
                    state_d = ST_WAIT;
                    cnt_d   = long_q ? LD_LONG : LD_SHORT;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_WAIT: begin
                busy_d = 1'b1;
                if (cnt_zero) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= 8'h00;
            rs_q    <= 1'b0;
            ack_q   <= 1'b0;
            long_q  <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
            ack_q   <= ack_d;
            long_q  <= long_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
        end
    end

    assign lcd_data    = data_q;
    assign lcd_rs      = rs_q;
    assign lcd_rw      = 1'b0;
    assign lcd_en      = en_q;
    assign busy        = busy_q;
    assign status_word = {ack_q, 30'd0, busy_q};

endmodule
